audio_fifo_frame_scheduler: RTL and testbench
=============================================

Name: audio_fifo_frame_scheduler

Overview:
Write-side controller for the 32-bit sample FIFO that the Nios II reads through its q/rdempty/rdfull/rdreq PIOs. Takes stereo 16-bit codec samples, decimates them, packs each pair into 32-bit words and writes them into the FIFO in whole frames of FRAME_LEN words. A frame starts only when the FIFO has room for all of it, so the CPU never sees a partial frame. Frames without room are skipped and counted.

Parameters:
FRAME_LEN, 256, words per frame (>=1)
FIFO_DEPTH, 1024, FIFO capacity in words
USEDW_W, 10, width of fifo_wrusedw
DECIM, 1, keep 1 of every DECIM input samples (1..16)
CNT_W, 16, width of drop_count

Ports:
clk_clk  in  1  system clock
reset_reset  in  1  synchronous, active-high reset
enable  in  1  permits new frames to start
sample_valid  in  1  one-cycle strobe: sample_left/right valid
sample_left  in  16  left channel sample
sample_right  in  16  right channel sample
fifo_wrusedw  in  USEDW_W  FIFO write-side fill level
fifo_wrfull  in  1  FIFO full
fifo_data  out  32  {sample_left, sample_right}
fifo_wrreq  out  1  FIFO write strobe
frame_active  out  1  high while a frame is being written
frame_done  out  1  one-cycle pulse, coincident with the last word's fifo_wrreq
drop_count  out  CNT_W  frames skipped, saturating
overflow_err  out  1  sticky: a write was suppressed by fifo_wrfull inside a frame

Behaviour:
- Reset: state IDLE. dcnt, wcnt, drop_count = 0. fifo_wrreq, frame_done, frame_active, overflow_err = 0. fifo_data = 0. Reset mid-frame abandons the frame at once; words already written stay in the FIFO.
- Decimator: dcnt counts 0..DECIM-1 and advances on each sample_valid, wrapping at DECIM-1. A sample_valid with dcnt==0 is a "candidate". In IDLE with enable=0, dcnt is held at 0.
- IDLE, on a candidate with enable=1:
  - If fifo_wrfull=0 and fifo_wrusedw <= FIFO_DEPTH-FRAME_LEN, write the candidate as word 0, set wcnt=1 and go to FILL.
  - If FRAME_LEN==1, stay in IDLE and pulse frame_done instead.
  - Otherwise go to SKIP, set wcnt=1 and increment drop_count, saturating at all-ones.
- IDLE with enable=0: candidates are ignored and nothing is counted.
- FILL: every candidate is written and wcnt increments. When the word with wcnt==FRAME_LEN-1 is written, assert frame_done with that write and return to IDLE. enable is ignored in FILL; a frame always completes.
- SKIP: every candidate is discarded and wcnt increments. After FRAME_LEN candidates in total, return to IDLE. No writes occur. This keeps frame alignment to the sample stream.
- Write timing: latency is 1 cycle. fifo_wrreq and fifo_data are registered in the cycle after the accepted sample_valid, with fifo_data={sample_left,sample_right}. fifo_data holds its value when no write occurs.
- If fifo_wrfull=1 at a candidate in FILL: suppress fifo_wrreq, set overflow_err until reset, and still count the word in wcnt, so the frame boundary is preserved.
- frame_active = (state==FILL), registered. It rises on the cycle of the word-0 write and falls on the cycle after frame_done.
- Back-to-back sample_valid on consecutive cycles must be supported: one write per cycle, no stalls.
- The free-space check uses fifo_wrusedw as sampled on the candidate cycle. There is no lookahead for the write in flight.

Test Plan:
- FRAME_LEN=4, DEPTH=16, DECIM=1, usedw=0, enable=1, 4 samples (L=0x1111..0x4444, R=0xA000..0xA003) -> 4 wrreq, fifo_data 0x1111A000..0x4444A003, each 1 cycle after its strobe; frame_done with the 4th; frame_active high for exactly that window.
- DECIM=2, 8 samples -> only samples 0,2,4,6 written; one frame_done.
- usedw=13 (>12) at first candidate -> no wrreq for 4 candidates, drop_count=1. usedw=12 at the 5th candidate -> frame written.
- CNT_W=2 with 5 consecutive skipped frames -> drop_count sticks at 3.
- enable dropped after word 1 -> words 2..3 still written and frame_done asserted; next candidates ignored, drop_count unchanged.
- Reset asserted after word 2 -> next cycle all outputs 0 and state IDLE; the following frame restarts at word 0. Also: fifo_wrfull=1 at word 3 -> no wrreq for word 3, overflow_err=1, frame_done still pulses on word 4's cycle.

Source files
------------

// File: rtl/audio_fifo_frame_scheduler.sv
// Write-side frame scheduler for the Nios II sample FIFO: decimates stereo samples,
// packs them into 32-bit words and writes whole frames only when the FIFO has room.
module audio_fifo_frame_scheduler #(
    parameter int FRAME_LEN  = 256,
    parameter int FIFO_DEPTH = 1024,
    parameter int USEDW_W    = 10,
    parameter int DECIM      = 1,
    parameter int CNT_W      = 16
) (
    input  logic               clk_clk,
    input  logic               reset_reset,
    input  logic               enable,
    input  logic               sample_valid,
    input  logic [15:0]        sample_left,
    input  logic [15:0]        sample_right,
    input  logic [USEDW_W-1:0] fifo_wrusedw,
    input  logic               fifo_wrfull,
    output logic [31:0]        fifo_data,
    output logic               fifo_wrreq,
    output logic               frame_active,
    output logic               frame_done,
    output logic [CNT_W-1:0]   drop_count,
    output logic               overflow_err
);

    localparam int DCNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int WCNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DECIM - 1);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(FRAME_LEN - 1);
    localparam int unsigned ROOM_LIMIT = FIFO_DEPTH - FRAME_LEN;

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_SKIP} state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [DCNT_W-1:0]   r_dcnt;
    logic [DCNT_W-1:0]   w_dcnt_next;
    logic [WCNT_W-1:0]   r_wcnt;
    logic [WCNT_W-1:0]   w_wcnt_next;
    logic [31:0]         r_fifo_data;
    logic                r_wrreq;
    logic                r_done;
    logic                r_active;
    logic [CNT_W-1:0]    r_drop;
    logic                r_ovf;

    logic w_candidate;
    logic w_room;
    logic w_write;
    logic w_done;
    logic w_drop_inc;
    logic w_ovf_set;

    assign w_candidate = sample_valid && (r_dcnt == '0);
    // Free space is judged on the current fill level only; the write in flight is not counted.
    assign w_room = !fifo_wrfull && (32'(fifo_wrusedw) <= ROOM_LIMIT);

    always_comb begin
        w_dcnt_next = r_dcnt;
        if (r_state == S_IDLE && !enable) begin
            w_dcnt_next = '0;
        end else if (sample_valid) begin
            w_dcnt_next = (r_dcnt == DCNT_LAST) ? '0 : r_dcnt + 1'b1;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_wcnt_next  = r_wcnt;
        w_write      = 1'b0;
        w_done       = 1'b0;
        w_drop_inc   = 1'b0;
        w_ovf_set    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_candidate && enable) begin
                    if (w_room) begin
                        w_write = 1'b1;
                        if (FRAME_LEN == 1) begin
                            w_done = 1'b1;
                        end else begin
                            w_state_next = S_FILL;
                            w_wcnt_next  = WCNT_W'(1);
                        end
                    end else begin
                        w_drop_inc = 1'b1;
                        if (FRAME_LEN > 1) begin
                            w_state_next = S_SKIP;
                            w_wcnt_next  = WCNT_W'(1);
                        end
                    end
                end
            end
            S_FILL: begin
                if (w_candidate) begin
                    // A word refused by a full FIFO still occupies its slot in the frame.
                    if (fifo_wrfull) begin
                        w_ovf_set = 1'b1;
                    end else begin
                        w_write = 1'b1;
                    end
                    if (r_wcnt == WCNT_LAST) begin
                        w_done       = 1'b1;
                        w_state_next = S_IDLE;
                        w_wcnt_next  = '0;
                    end else begin
                        w_wcnt_next = r_wcnt + 1'b1;
                    end
                end
            end
            S_SKIP: begin
                if (w_candidate) begin
                    if (r_wcnt == WCNT_LAST) begin
                        w_state_next = S_IDLE;
                        w_wcnt_next  = '0;
                    end else begin
                        w_wcnt_next = r_wcnt + 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_wcnt_next  = '0;
            end
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_state     <= S_IDLE;
            r_dcnt      <= '0;
            r_wcnt      <= '0;
            r_fifo_data <= '0;
            r_wrreq     <= 1'b0;
            r_done      <= 1'b0;
            r_active    <= 1'b0;
            r_drop      <= '0;
            r_ovf       <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_dcnt   <= w_dcnt_next;
            r_wcnt   <= w_wcnt_next;
            r_wrreq  <= w_write;
            r_done   <= w_done;
            // Active spans the word-0 write through the frame_done cycle.
            r_active <= (w_state_next == S_FILL) || (r_state == S_FILL && w_done);
            if (w_write) begin
                r_fifo_data <= {sample_left, sample_right};
            end
            if (w_drop_inc && (r_drop != '1)) begin
                r_drop <= r_drop + 1'b1;
            end
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign fifo_data    = r_fifo_data;
    assign fifo_wrreq   = r_wrreq;
    assign frame_active = r_active;
    assign frame_done   = r_done;
    assign drop_count   = r_drop;
    assign overflow_err = r_ovf;

endmodule

// File: tb/tb_audio_fifo_frame_scheduler.sv
// Directed bench for audio_fifo_frame_scheduler: instance A (DECIM=1, CNT_W=2) and
// instance B (DECIM=2) share stimulus; expected values are hand-computed.
module tb_audio_fifo_frame_scheduler;

    logic        clk;
    logic        srst;
    logic        enable;
    logic        sample_valid;
    logic [15:0] sample_left;
    logic [15:0] sample_right;
    logic [4:0]  usedw;
    logic        wrfull;

    logic [31:0] a_data, b_data;
    logic        a_wrreq, b_wrreq;
    logic        a_active, b_active;
    logic        a_done, b_done;
    logic [1:0]  a_drop;
    logic [15:0] b_drop;
    logic        a_ovf, b_ovf;

    int n_total = 0;
    int n_bad   = 0;

    audio_fifo_frame_scheduler #(
        .FRAME_LEN(4), .FIFO_DEPTH(16), .USEDW_W(5), .DECIM(1), .CNT_W(2)
    ) u_dut_a (
        .clk_clk(clk), .reset_reset(srst), .enable(enable),
        .sample_valid(sample_valid), .sample_left(sample_left), .sample_right(sample_right),
        .fifo_wrusedw(usedw), .fifo_wrfull(wrfull),
        .fifo_data(a_data), .fifo_wrreq(a_wrreq), .frame_active(a_active),
        .frame_done(a_done), .drop_count(a_drop), .overflow_err(a_ovf)
    );

    audio_fifo_frame_scheduler #(
        .FRAME_LEN(4), .FIFO_DEPTH(16), .USEDW_W(5), .DECIM(2), .CNT_W(16)
    ) u_dut_b (
        .clk_clk(clk), .reset_reset(srst), .enable(enable),
        .sample_valid(sample_valid), .sample_left(sample_left), .sample_right(sample_right),
        .fifo_wrusedw(usedw), .fifo_wrfull(wrfull),
        .fifo_data(b_data), .fifo_wrreq(b_wrreq), .frame_active(b_active),
        .frame_done(b_done), .drop_count(b_drop), .overflow_err(b_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the next negedge with that edge's outputs visible.
    task automatic step(input logic v, input logic [15:0] l, input logic [15:0] r);
        sample_valid = v;
        sample_left  = l;
        sample_right = r;
        @(negedge clk);
        sample_valid = 1'b0;
        if (v)
            $display("t=%0t sample L=%h R=%h en=%0b usedw=%0d full=%0b -> A wrreq=%0b data=%h done=%0b drop=%0d",
                     $time, l, r, enable, usedw, wrfull, a_wrreq, a_data, a_done, a_drop);
    endtask

    task automatic do_reset();
        srst = 1'b1;
        step(1'b0, 16'h0, 16'h0);
        step(1'b0, 16'h0, 16'h0);
        srst = 1'b0;
    endtask

    initial begin
        srst = 1'b1; enable = 1'b0; sample_valid = 1'b0;
        sample_left = '0; sample_right = '0; usedw = '0; wrfull = 1'b0;
        @(negedge clk);
        do_reset();
        check("rst_wrreq", 32'(a_wrreq), 32'd0);
        check("rst_data", a_data, 32'd0);
        check("rst_active", 32'(a_active), 32'd0);
        check("rst_done", 32'(a_done), 32'd0);
        check("rst_drop", 32'(a_drop), 32'd0);
        check("rst_ovf", 32'(a_ovf), 32'd0);

        // Basic frame, back-to-back samples
        enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            logic [15:0] l, r;
            l = 16'h1111 * 16'(i + 1);
            r = 16'hA000 + 16'(i);
            step(1'b1, l, r);
            check($sformatf("basic_wrreq%0d", i), 32'(a_wrreq), 32'd1);
            check($sformatf("basic_data%0d", i), a_data, {l, r});
            check($sformatf("basic_done%0d", i), 32'(a_done), 32'(i == 3));
            check($sformatf("basic_active%0d", i), 32'(a_active), 32'd1);
        end
        step(1'b0, 16'h0, 16'h0);
        check("basic_idle_wrreq", 32'(a_wrreq), 32'd0);
        check("basic_idle_active", 32'(a_active), 32'd0);
        check("basic_hold_data", a_data, 32'h4444A003);

        // Decimation by 2 on instance B
        do_reset();
        for (int i = 0; i < 8; i++) begin
            logic [15:0] l, r;
            l = 16'h1000 + 16'(i);
            r = 16'h2000 + 16'(i);
            step(1'b1, l, r);
            check($sformatf("decim_wrreq%0d", i), 32'(b_wrreq), 32'(i % 2 == 0));
            check($sformatf("decim_data%0d", i), b_data,
                  {16'h1000 + 16'(i - i % 2), 16'h2000 + 16'(i - i % 2)});
            check($sformatf("decim_done%0d", i), 32'(b_done), 32'(i == 6));
            check($sformatf("decim_active%0d", i), 32'(b_active), 32'(i <= 6));
        end

        // Skip when short of room, then write once room is back
        do_reset();
        usedw = 5'd13;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 16'h5500 + 16'(i), 16'h6600);
            check($sformatf("skip_wrreq%0d", i), 32'(a_wrreq), 32'd0);
            check($sformatf("skip_drop%0d", i), 32'(a_drop), 32'd1);
        end
        usedw = 5'd12;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 16'h7700 + 16'(i), 16'h8800);
            check($sformatf("room_wrreq%0d", i), 32'(a_wrreq), 32'd1);
            check($sformatf("room_done%0d", i), 32'(a_done), 32'(i == 3));
        end
        check("room_drop", 32'(a_drop), 32'd1);

        // drop_count saturates at 3 with CNT_W=2
        do_reset();
        usedw = 5'd13;
        for (int f = 0; f < 5; f++) begin
            for (int k = 0; k < 4; k++) step(1'b1, 16'h0F00, 16'h00F0);
            check($sformatf("sat_drop_f%0d", f), 32'(a_drop), (f >= 2) ? 32'd3 : 32'(f + 1));
        end
        check("sat_no_write", 32'(a_wrreq), 32'd0);

        // enable removed mid-frame: frame completes, later candidates ignored
        do_reset();
        usedw = 5'd0;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) enable = 1'b0;
            step(1'b1, 16'h3000 + 16'(i), 16'h4000);
            check($sformatf("en_wrreq%0d", i), 32'(a_wrreq), 32'd1);
            check($sformatf("en_done%0d", i), 32'(a_done), 32'(i == 3));
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 16'hDEAD, 16'hBEEF);
            check($sformatf("en_off_wrreq%0d", i), 32'(a_wrreq), 32'd0);
        end
        check("en_off_drop", 32'(a_drop), 32'd0);
        check("en_off_data", a_data, 32'h30034000);
        enable = 1'b1;

        // Reset mid-frame, then a fresh frame starts at word 0
        step(1'b1, 16'h0A00, 16'h0B00);
        step(1'b1, 16'h0A01, 16'h0B01);
        check("mid_pre_active", 32'(a_active), 32'd1);
        srst = 1'b1;
        step(1'b0, 16'h0, 16'h0);
        srst = 1'b0;
        check("mid_rst_wrreq", 32'(a_wrreq), 32'd0);
        check("mid_rst_data", a_data, 32'd0);
        check("mid_rst_active", 32'(a_active), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 16'h0C00 + 16'(i), 16'h0D00);
            check($sformatf("restart_done%0d", i), 32'(a_done), 32'(i == 3));
            check($sformatf("restart_data%0d", i), a_data, {16'h0C00 + 16'(i), 16'h0D00});
        end

        // FIFO full on the third word of a frame
        for (int i = 0; i < 4; i++) begin
            wrfull = (i == 2);
            step(1'b1, 16'h0E00 + 16'(i), 16'h0F00);
            check($sformatf("full_wrreq%0d", i), 32'(a_wrreq), 32'(i != 2));
            check($sformatf("full_ovf%0d", i), 32'(a_ovf), 32'(i >= 2));
            check($sformatf("full_done%0d", i), 32'(a_done), 32'(i == 3));
            check($sformatf("full_data%0d", i), a_data,
                  {16'h0E00 + 16'((i == 2) ? 1 : i), 16'h0F00});
        end
        wrfull = 1'b0;
        step(1'b0, 16'h0, 16'h0);
        check("full_ovf_sticky", 32'(a_ovf), 32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
